// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  // Widest 2*WIDTH product the negate helper has to handle.
  localparam int unsigned MDU_MAX_W = 128;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mdu_state_t;

  // Two's-complement negate when neg is set; callers truncate to their own width.
  function automatic logic [MDU_MAX_W-1:0] cond_neg(input logic [MDU_MAX_W-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + MDU_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between control and the multiply/divide unit.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] arg1;
  logic [WIDTH-1:0] arg2;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, arg1, arg2,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, arg1, arg2,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU (one bit per cycle) into HI/LO, plus MTHI/MTLO.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned W2    = 2 * WIDTH;

  mdu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_out_q;

  logic             is_md;
  logic             is_signed;
  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_md     = bus.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    a_neg     = is_signed & bus.arg1[WIDTH-1];
    b_neg     = is_signed & bus.arg2[WIDTH-1];
    a_mag     = WIDTH'(cond_neg(MDU_MAX_W'(bus.arg1), a_neg));
    b_mag     = WIDTH'(cond_neg(MDU_MAX_W'(bus.arg2), b_neg));
  end

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_r;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    fix_prod;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  // acc_q holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_r    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_r >= {1'b0, opnd_q};
    div_rem  = div_ge ? WIDTH'(div_r - {1'b0, opnd_q}) : div_r[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
    fix_prod = W2'(cond_neg(MDU_MAX_W'(acc_q), neg_lo_q));
    fix_quo  = WIDTH'(cond_neg(MDU_MAX_W'(acc_q[WIDTH-1:0]), neg_lo_q));
    fix_rem  = WIDTH'(cond_neg(MDU_MAX_W'(acc_q[W2-1:WIDTH]), neg_hi_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          dz_out_q <= 1'b0;
          if (bus.start) begin
            if (is_md) begin
              state_q  <= RUN;
              busy_q   <= 1'b1;
              cnt_q    <= CNT_W'(WIDTH);
              acc_q    <= {{WIDTH{1'b0}}, a_mag};
              opnd_q   <= b_mag;
              is_div_q <= is_div;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= a_neg;
              dz_q     <= is_div && (bus.arg2 == '0);
            end else if (bus.op == OP_MTHI) begin
              hi_q <= bus.arg1;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.arg1;
            end
          end
        end
        RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          if (!is_div_q) begin
            {hi_q, lo_q} <= fix_prod;
          end else if (!dz_q) begin
            hi_q <= fix_rem;
            lo_q <= fix_quo;
          end
          state_q  <= DONE;
          done_q   <= 1'b1;
          dz_out_q <= dz_q;
        end
        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          dz_out_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed checks of mul_div_unit at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];

  mdu_if #(.WIDTH(32)) b32 ();
  mdu_if #(.WIDTH(8))  b8 ();

  mul_div_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  mul_div_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input mdu_op_t op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      b32.start = s; b32.op = op; b32.arg1 = a; b32.arg2 = b;
    end else begin
      b8.start = s; b8.op = op; b8.arg1 = a[7:0]; b8.arg2 = b[7:0];
    end
  endtask

  task automatic sample(input int w, output logic busy, output logic done, output logic dz,
                        output logic [31:0] hi, output logic [31:0] lo);
    if (w == 32) begin
      busy = b32.busy; done = b32.done; dz = b32.div_by_zero; hi = b32.hi; lo = b32.lo;
    end else begin
      busy = b8.busy; done = b8.done; dz = b8.div_by_zero;
      hi = {24'b0, b8.hi}; lo = {24'b0, b8.lo};
    end
  endtask

  // Architectural result of one op computed with plain integer arithmetic.
  task automatic model(input int w, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output logic dz);
    longint unsigned mask, ua, ub, up;
    longint          sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    ua = a & mask;
    ub = b & mask;
    sa = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    dz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb; hi = 32'((p >>> w) & mask); lo = 32'(p & mask); end
      OP_MULTU: begin up = ua * ub; hi = 32'(up >> w); lo = 32'(up & mask); end
      OP_DIV, OP_DIVU: begin
        if (ub == 0) dz = 1'b1;
        else if (op == OP_DIV) begin
          q = sa / sb; r = sa % sb;
          hi = 32'(r & mask); lo = 32'(q & mask);
        end else begin
          hi = 32'((ua % ub) & mask); lo = 32'((ua / ub) & mask);
        end
      end
      OP_MTHI: hi = a & 32'(mask);
      OP_MTLO: lo = a & 32'(mask);
      default: ;
    endcase
  endtask

  task automatic accept(input int w, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(w, 1'b0, mdu_op_t'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  // Entered #1 after an edge that is cycle c0 relative to acceptance; waits for done.
  task automatic wait_done(input int w, input int c0, output int cyc, output int busycnt,
                           output logic ok);
    logic bz, dn, dz;
    logic [31:0] h, l;
    sample(w, bz, dn, dz, h, l);
    cyc = c0;
    busycnt = 0;
    while (!dn && cyc < 300) begin
      if (bz) busycnt++;
      @(posedge clk);
      #1;
      sample(w, bz, dn, dz, h, l);
      cyc++;
    end
    ok = dn;
    if (!dn) chk("timeout_done", 64'd0, 64'd1);
  endtask

  task automatic run_md(input int w, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, output logic [31:0] ghi, output logic [31:0] glo);
    int k, cyc, bc;
    logic ok, bz, dn, dz, edz;
    logic [31:0] eh, el;
    k = (w == 32) ? 0 : 1;
    eh = m_hi[k];
    el = m_lo[k];
    model(w, op, a, b, eh, el, edz);
    m_hi[k] = eh;
    m_lo[k] = el;
    accept(w, op, a, b);
    wait_done(w, 1, cyc, bc, ok);
    sample(w, bz, dn, dz, ghi, glo);
    if (ok) begin
      chk({tag, "_latency"}, 64'(cyc), 64'(w + 2));
      chk({tag, "_busy_cycles"}, 64'(bc), 64'(w + 1));
      chk({tag, "_busy_at_done"}, 64'(bz), 64'd1);
      chk({tag, "_hi"}, 64'(ghi), 64'(eh));
      chk({tag, "_lo"}, 64'(glo), 64'(el));
      chk({tag, "_dz"}, 64'(dz), 64'(edz));
    end
    @(posedge clk);
    #1;
    sample(w, bz, dn, dz, eh, el);
    chk({tag, "_done_pulse"}, 64'(dn), 64'd0);
    chk({tag, "_dz_after"}, 64'(dz), 64'd0);
    chk({tag, "_idle_after"}, 64'(bz), 64'd0);
  endtask

  task automatic mt(input int w, input mdu_op_t op, input logic [31:0] a, input string tag);
    int k;
    logic bz, dn, dz, edz;
    logic [31:0] h, l, eh, el;
    k = (w == 32) ? 0 : 1;
    eh = m_hi[k];
    el = m_lo[k];
    model(w, op, a, 32'd0, eh, el, edz);
    m_hi[k] = eh;
    m_lo[k] = el;
    @(negedge clk);
    drive(w, 1'b1, op, a, 32'd0);
    @(posedge clk);
    #1;
    drive(w, 1'b0, OP_NOP7, 32'd0, 32'd0);
    sample(w, bz, dn, dz, h, l);
    chk({tag, "_busy"}, 64'(bz), 64'd0);
    chk({tag, "_done"}, 64'(dn), 64'd0);
    chk({tag, "_hi"}, 64'(h), 64'(eh));
    chk({tag, "_lo"}, 64'(l), 64'(el));
  endtask

  initial begin
    logic [31:0] gh, gl, a, b;
    logic bz, dn, dz, ok;
    int cyc, bc, dones;
    mdu_op_t op;

    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    drive(32, 1'b0, OP_NOP7, 32'd0, 32'd0);
    drive(8, 1'b0, OP_NOP7, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int w = 8; w <= 32; w += 24) begin
      sample(w, bz, dn, dz, gh, gl);
      chk("reset_busy", 64'(bz), 64'd0);
      chk("reset_done", 64'(dn), 64'd0);
      chk("reset_dz", 64'(dz), 64'd0);
      chk("reset_hi", 64'(gh), 64'd0);
      chk("reset_lo", 64'(gl), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_md(32, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", gh, gl);
    chk("multu_max_hi_plan", 64'(gh), 64'hFFFFFFFE);
    chk("multu_max_lo_plan", 64'(gl), 64'h00000001);
    run_md(32, OP_MULT, 32'hFFFFFFFD, 32'd7, "mult_neg", gh, gl);
    chk("mult_neg_lo_plan", 64'(gl), 64'hFFFFFFEB);
    run_md(32, OP_DIV, 32'hFFFFFFF9, 32'd2, "div_neg", gh, gl);
    chk("div_neg_lo_plan", 64'(gl), 64'hFFFFFFFD);
    chk("div_neg_hi_plan", 64'(gh), 64'hFFFFFFFF);
    run_md(32, OP_DIVU, 32'd7, 32'd2, "divu_7_2", gh, gl);
    run_md(32, OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min_m1", gh, gl);
    chk("div_min_m1_lo_plan", 64'(gl), 64'h80000000);

    mt(32, OP_MTHI, 32'h1234, "mthi");
    mt(32, OP_MTLO, 32'h5678, "mtlo");
    run_md(32, OP_DIV, 32'd9, 32'd0, "div_zero", gh, gl);
    chk("div_zero_hi_kept", 64'(gh), 64'h1234);
    mt(32, OP_NOP6, 32'hDEADBEEF, "nop6");

    // MTLO raised mid-multiply must be dropped.
    accept(32, OP_MULTU, 32'd2, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    drive(32, 1'b1, OP_MTLO, 32'hAAAA, 32'd0);
    @(posedge clk);
    #1;
    drive(32, 1'b0, OP_NOP7, 32'd0, 32'd0);
    wait_done(32, 6, cyc, bc, ok);
    sample(32, bz, dn, dz, gh, gl);
    chk("busy_ignore_latency", 64'(cyc), 64'd34);
    chk("busy_ignore_hi", 64'(gh), 64'd0);
    chk("busy_ignore_lo", 64'(gl), 64'd6);
    m_hi[0] = 32'd0;
    m_lo[0] = 32'd6;
    @(posedge clk);
    #1;

    accept(32, OP_DIVU, 32'hCAFEF00D, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sample(32, bz, dn, dz, gh, gl);
    chk("rst_mid_hi", 64'(gh), 64'd0);
    chk("rst_mid_lo", 64'(gl), 64'd0);
    chk("rst_mid_busy", 64'(bz), 64'd0);
    chk("rst_mid_done", 64'(dn), 64'd0);
    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (b32.done) dones++;
    end
    chk("rst_no_done", 64'(dones), 64'd0);
    run_md(32, OP_MULTU, 32'd4, 32'd5, "multu_4_5", gh, gl);
    chk("multu_4_5_lo_plan", 64'(gl), 64'd20);

    run_md(8, OP_DIV, 32'h80, 32'hFF, "w8_min_m1", gh, gl);
    run_md(8, OP_MULT, 32'h80, 32'h80, "w8_min_sq", gh, gl);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mt(8, ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom, "w8_mt");
      end else begin
        op = mdu_op_t'($urandom_range(0, 3));
        a  = $urandom;
        b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        run_md(8, op, a, b, "w8_rand", gh, gl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
